// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared hazard-unit types and the forwarding select helper
package hazard_unit_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} hazard_state_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  // EX/MEM wins over MEM/WB; x0 is never forwarded
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs, input logic [4:0] mem_rd,
                                        input logic mem_we, input logic [4:0] wb_rd,
                                        input logic wb_we);
    return (mem_we && mem_rd != 5'd0 && mem_rd == rs) ? FWD_MEM :
           (wb_we && wb_rd != 5'd0 && wb_rd == rs) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side signals of the hazard unit (perf counters under HAZARD_UNIT_PERF_EN)
interface hazard_unit_if;
  import hazard_unit_pkg::*;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_error;
  fwd_sel_t   fwd_a, fwd_b;
`ifdef HAZARD_UNIT_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    output ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_error, fwd_a, fwd_b
`ifdef HAZARD_UNIT_PERF_EN
    , input stall_cycles, flush_count
`endif
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    input  ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_error, fwd_a, fwd_b
`ifdef HAZARD_UNIT_PERF_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_unit_forwarding_unit.sv
// forwarding_unit: combinational ALU operand source selection
module forwarding_unit import hazard_unit_pkg::*; (
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output fwd_sel_t   o_fwd_a,
  output fwd_sel_t   o_fwd_b
);
  assign o_fwd_a = fwd_pick(i_ex_rs1, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);
  assign o_fwd_b = fwd_pick(i_ex_rs2, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use/branch/memory-wait stall control and forwarding; HAZARD_UNIT_PERF_EN adds perf counters
module hazard_unit import hazard_unit_pkg::*; #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hif
);
  hazard_state_t r_state;
  logic [7:0]    r_wait_cnt;
  fwd_sel_t      w_fwd_a, w_fwd_b;
  logic          w_run, w_mem_stall, w_load_use, w_timeout, w_pc_write, w_if_id_flush;

  forwarding_unit u_fwd (
    .i_ex_rs1(hif.ex_rs1), .i_ex_rs2(hif.ex_rs2),
    .i_mem_rd(hif.mem_rd), .i_mem_reg_write(hif.mem_reg_write),
    .i_wb_rd(hif.wb_rd), .i_wb_reg_write(hif.wb_reg_write),
    .o_fwd_a(w_fwd_a), .o_fwd_b(w_fwd_b)
  );

  assign w_run       = r_state == RUN;
  assign w_mem_stall = !hif.mem_ready && (r_state == MEM_WAIT || (w_run && hif.mem_req));
  assign w_load_use  = w_run && !w_mem_stall && hif.ex_mem_read && hif.ex_rd != 5'd0 &&
                       (hif.ex_rd == hif.id_rs1 || hif.ex_rd == hif.id_rs2);
  assign w_timeout   = r_state == MEM_WAIT && !hif.mem_ready && r_wait_cnt == 8'(MEM_TIMEOUT - 1);
  assign w_pc_write    = rst && !w_mem_stall && !w_load_use;
  assign w_if_id_flush = rst && w_run && !w_mem_stall && !w_load_use && hif.branch_taken;

  assign hif.pc_write    = w_pc_write;
  assign hif.if_id_write = w_pc_write;
  assign hif.if_id_flush = w_if_id_flush;
  assign hif.id_ex_flush = rst && w_load_use;
  assign hif.pipe_hold   = rst && w_mem_stall;
  assign hif.mem_error   = rst && r_state == ERR;
  assign hif.fwd_a       = rst ? w_fwd_a : FWD_RF;
  assign hif.fwd_b       = rst ? w_fwd_b : FWD_RF;

  // memory-wait FSM: ERR lasts one cycle and always returns to RUN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else
      case (r_state)
        RUN: if (hif.mem_req && !hif.mem_ready) begin
          r_state    <= MEM_WAIT;
          r_wait_cnt <= '0;
        end
        MEM_WAIT: if (hif.mem_ready) r_state <= RUN;
          else if (w_timeout) r_state <= ERR;
          else r_wait_cnt <= r_wait_cnt + 8'd1;
        default: r_state <= RUN;
      endcase

`ifdef HAZARD_UNIT_PERF_EN
  logic [31:0] r_stall_cycles, r_flush_count;
  // count stalled and flushed cycles, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pc_write) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_if_id_flush) r_flush_count <= r_flush_count + 32'd1;
    end
  assign hif.stall_cycles = r_stall_cycles;
  assign hif.flush_count  = r_flush_count;
`endif
endmodule
